// File: rtl/sat_arith_pkg.sv
// sat_arith_pkg: shared saturation limits and frame counter width helper.
package sat_arith_pkg;
   typedef int unsigned cnt_width_t;
   function automatic longint max_pos(input int w);
      return (longint'(1) << (w - 1)) - 1;
   endfunction
   function automatic longint min_neg(input int w);
      return -(longint'(1) << (w - 1));
   endfunction
   function automatic cnt_width_t cnt_w(input int n);
      return (n > 1) ? cnt_width_t'($clog2(n)) : 1;
   endfunction
endpackage

// File: rtl/sat_add_w.sv
// sat_add_w: W-bit two's complement adder that clamps on signed overflow.
module sat_add_w
   import sat_arith_pkg::*;
#(
   parameter int W = 4
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] sum,
   output logic                sat
);
   logic signed [W-1:0] s;
   logic                pos_ovf;
   logic                neg_ovf;
   assign s       = a + b;
   assign pos_ovf = !a[W-1] && !b[W-1] && s[W-1];
   assign neg_ovf = a[W-1] && b[W-1] && !s[W-1];
   assign sat     = pos_ovf || neg_ovf;
   assign sum     = pos_ovf ? W'(max_pos(W)) : neg_ovf ? W'(min_neg(W)) : s;
endmodule

// File: rtl/sat_frame_accumulator.sv
// sat_frame_accumulator: per-frame saturating sum of N samples, one-cycle result pulse.
// Define SAT_FRAME_ACCUMULATOR_STICKY_EN to report per-frame saturation on res_sat.
module sat_frame_accumulator
   import sat_arith_pkg::*;
#(
   parameter int W = 4,
   parameter int N = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                arg_vld,
   input  logic signed [W-1:0] arg,
   output logic                res_vld,
   output logic signed [W-1:0] res,
   output logic                res_sat
);
   localparam int CW = int'(cnt_w(N));
   logic [CW-1:0]       cnt;
   logic signed [W-1:0] acc;
   logic signed [W-1:0] acc_next;
   logic signed [W-1:0] step_sum;
   logic                step_sat;
   logic                first;
   logic                last;
   sat_add_w #(.W(W)) u_add (
      .a  (acc),
      .b  (arg),
      .sum(step_sum),
      .sat(step_sat)
   );
   assign first    = cnt == '0;
   assign last     = cnt == CW'(N - 1);
   assign acc_next = first ? arg : step_sum;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         acc     <= '0;
         res     <= '0;
         res_vld <= 1'b0;
      end else begin
         res_vld <= arg_vld && last;
         if (arg_vld) begin
            if (last) begin
               res <= acc_next;
               cnt <= '0;
            end else begin
               acc <= acc_next;
               cnt <= cnt + 1'b1;
            end
         end
      end
   end
`ifdef SAT_FRAME_ACCUMULATOR_STICKY_EN
   logic sat_acc;
   logic sat_next;
   assign sat_next = first ? 1'b0 : (sat_acc | step_sat);
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_acc <= 1'b0;
         res_sat <= 1'b0;
      end else if (arg_vld) begin
         if (last) res_sat <= sat_next;
         else sat_acc <= sat_next;
      end
   end
`else
   logic unused_step_sat;
   assign unused_step_sat = step_sat;
   assign res_sat         = 1'b0;
`endif
endmodule
